// File: rtl/reg_pkg.sv
// reg_pkg: shared register-file widths and the writeback entry type.
package reg_pkg;
  localparam int REG_DATA_WIDTH_POW = 6;
  localparam int REG_MEM_DEPTH_POW = 5;
  localparam int REG_DATA_WIDTH = 1 << REG_DATA_WIDTH_POW;
  localparam int REG_MEM_DEPTH = 1 << REG_MEM_DEPTH_POW;
  typedef logic [REG_MEM_DEPTH_POW-1:0] reg_idx_t;
  typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;
  typedef struct packed {
    reg_idx_t rd;
    reg_data_t data;
  } wb_entry_t;
endpackage

// File: rtl/wb_ld_fifo.sv
// wb_ld_fifo: synchronous FIFO of writeback entries with per-slot valid/rd taps.
module wb_ld_fifo
  import reg_pkg::*;
#(
  parameter int DEPTH_POW = 2
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                push_in,
  input  wb_entry_t                           push_entry_in,
  input  logic                                pop_in,
  output logic                                full_out,
  output logic                                empty_out,
  output wb_entry_t                           head_out,
  output logic [(1<<DEPTH_POW)-1:0]           valid_out,
  output reg_idx_t [(1<<DEPTH_POW)-1:0]       rds_out
);
  logic [DEPTH_POW-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_POW:0] r_count;
  wb_entry_t r_mem [1<<DEPTH_POW];
  always_ff @(posedge clk_in) begin
    if (push_in) r_mem[r_wr_ptr] <= push_entry_in;
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + DEPTH_POW'(push_in);
      r_rd_ptr <= r_rd_ptr + DEPTH_POW'(pop_in);
      r_count <= r_count + (DEPTH_POW+1)'(push_in) - (DEPTH_POW+1)'(pop_in);
    end
  end
  assign full_out = r_count[DEPTH_POW];
  assign empty_out = r_count == '0;
  assign head_out = r_mem[r_rd_ptr];
  // A slot is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < (1 << DEPTH_POW); i++) begin : g_slot
    logic [DEPTH_POW-1:0] w_off;
    assign w_off = DEPTH_POW'(i) - r_rd_ptr;
    assign valid_out[i] = {1'b0, w_off} < r_count;
    assign rds_out[i] = r_mem[i].rd;
  end
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU and buffered load results into the single reg_file write port.
module reg_writeback
  import reg_pkg::*;
#(
  parameter int LD_FIFO_DEPTH_POW = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      alu_valid_in,
  output logic                      alu_ready_out,
  input  logic [REG_MEM_DEPTH_POW-1:0] alu_rd_in,
  input  logic [REG_DATA_WIDTH-1:0] alu_data_in,
  input  logic                      ld_valid_in,
  output logic                      ld_ready_out,
  input  logic [REG_MEM_DEPTH_POW-1:0] ld_rd_in,
  input  logic [REG_DATA_WIDTH-1:0] ld_data_in,
  output logic [REG_MEM_DEPTH_POW-1:0] rd_out,
  output logic [REG_DATA_WIDTH-1:0] data_write_out,
  output logic                      write_en_out,
  output logic [REG_MEM_DEPTH-1:0]  busy_mask_out,
  output logic                      fwd_valid_out
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int LD = 1 << LD_FIFO_DEPTH_POW;
  logic w_full, w_empty, w_ld_grant, w_push, w_src_vld;
  wb_entry_t w_head, w_src;
  logic [LD-1:0] w_valid;
  reg_idx_t [LD-1:0] w_rds;
  logic [SW-1:0] r_starve_cnt;
  logic r_we;
  reg_idx_t r_rd;
  reg_data_t r_data;
  wb_ld_fifo #(.DEPTH_POW(LD_FIFO_DEPTH_POW)) u_fifo (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .push_in(w_push),
    .push_entry_in({ld_rd_in, ld_data_in}),
    .pop_in(w_ld_grant),
    .full_out(w_full),
    .empty_out(w_empty),
    .head_out(w_head),
    .valid_out(w_valid),
    .rds_out(w_rds)
  );
  assign w_ld_grant = !w_empty && (!alu_valid_in || r_starve_cnt == SW'(STARVE_LIMIT));
  assign alu_ready_out = !rst_in && !w_ld_grant;
  assign ld_ready_out = !rst_in && !w_full;
  assign w_push = ld_valid_in && ld_ready_out;
  assign w_src_vld = w_ld_grant || alu_valid_in;
  assign w_src = w_ld_grant ? w_head : {alu_rd_in, alu_data_in};
  // A non-empty FIFO that is not granted implies an ALU win, so the counter only
  // grows while below the limit; reaching the limit forces a grant and a clear.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_we <= 1'b0;
      r_rd <= '0;
      r_data <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_we <= w_src_vld && w_src.rd != '0;
      if (w_src_vld) begin
        r_rd <= w_src.rd;
        r_data <= w_src.data;
      end
      r_starve_cnt <= (w_empty || w_ld_grant) ? '0 : r_starve_cnt + 1'b1;
    end
  end
  always_comb begin
    busy_mask_out = '0;
    for (int i = 0; i < LD; i++) if (w_valid[i]) busy_mask_out[w_rds[i]] = 1'b1;
    busy_mask_out[0] = 1'b0;
  end
  assign rd_out = r_rd;
  assign data_write_out = r_data;
  assign write_en_out = r_we;
  assign fwd_valid_out = r_we;
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed-vector bench for the writeback stage.
module tb_reg_writeback;
  import reg_pkg::*;
  logic clk = 1'b0;
  logic rst, alu_valid, alu_ready, ld_valid, ld_ready, write_en, fwd_valid;
  logic [4:0] alu_rd, ld_rd, rd;
  logic [63:0] alu_data, ld_data, data_w;
  logic [31:0] busy;
  logic [63:0] regs [32];
  wb_entry_t q[$];
  logic rec = 1'b0;
  int n_vec = 0, n_err = 0;
  reg_writeback dut (
    .clk_in(clk), .rst_in(rst),
    .alu_valid_in(alu_valid), .alu_ready_out(alu_ready), .alu_rd_in(alu_rd), .alu_data_in(alu_data),
    .ld_valid_in(ld_valid), .ld_ready_out(ld_ready), .ld_rd_in(ld_rd), .ld_data_in(ld_data),
    .rd_out(rd), .data_write_out(data_w), .write_en_out(write_en),
    .busy_mask_out(busy), .fwd_valid_out(fwd_valid)
  );
  always #5 clk = ~clk;
  // Behavioural reg_file sink plus a write log for ordering checks.
  always @(negedge clk) begin
    if (write_en) regs[rd] = data_w;
    if (rec && write_en) q.push_back(wb_entry_t'{rd: rd, data: data_w});
  end
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic mid;
    @(negedge clk);
  endtask
  task automatic test_reset;
    rst = 1; alu_valid = 0; alu_rd = 0; alu_data = 0; ld_valid = 0; ld_rd = 0; ld_data = 0;
    cyc; cyc; mid;
    n_vec++; if (write_en !== 1'b0) begin n_err++; $display("FAIL reset_we got %0h want 0", write_en); end
    n_vec++; if (rd !== 5'd0) begin n_err++; $display("FAIL reset_rd got %0h want 0", rd); end
    n_vec++; if (data_w !== 64'd0) begin n_err++; $display("FAIL reset_data got %0h want 0", data_w); end
    n_vec++; if (busy !== 32'd0) begin n_err++; $display("FAIL reset_busy got %0h want 0", busy); end
    n_vec++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL reset_alu_ready got %0h want 0", alu_ready); end
    n_vec++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL reset_ld_ready got %0h want 0", ld_ready); end
    cyc; rst = 0;
  endtask
  task automatic test_alu_only;
    alu_valid = 1; alu_rd = 3; alu_data = 64'hDEAD_BEEF;
    mid;
    n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL alu_ready got %0h want 1", alu_ready); end
    cyc; alu_valid = 0; mid;
    n_vec++; if (write_en !== 1'b1) begin n_err++; $display("FAIL alu_we got %0h want 1", write_en); end
    n_vec++; if (rd !== 5'd3) begin n_err++; $display("FAIL alu_rd got %0h want 3", rd); end
    n_vec++; if (data_w !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL alu_data got %0h want deadbeef", data_w); end
    n_vec++; if (fwd_valid !== 1'b1) begin n_err++; $display("FAIL alu_fwd got %0h want 1", fwd_valid); end
    cyc; mid;
    n_vec++; if (regs[3] !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL alu_x3 got %0h want deadbeef", regs[3]); end
    n_vec++; if (write_en !== 1'b0) begin n_err++; $display("FAIL alu_idle_we got %0h want 0", write_en); end
    cyc;
  endtask
  task automatic test_load_idle;
    ld_valid = 1; ld_rd = 9; ld_data = 64'h1234;
    mid;
    n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL ld_ready got %0h want 1", ld_ready); end
    n_vec++; if (busy !== 32'd0) begin n_err++; $display("FAIL ld_busy_pre got %0h want 0", busy); end
    cyc; ld_valid = 0; mid;
    n_vec++; if (busy !== 32'h200) begin n_err++; $display("FAIL ld_busy got %0h want 200", busy); end
    n_vec++; if (write_en !== 1'b0) begin n_err++; $display("FAIL ld_we_early got %0h want 0", write_en); end
    cyc; mid;
    n_vec++; if (busy !== 32'd0) begin n_err++; $display("FAIL ld_busy_post got %0h want 0", busy); end
    n_vec++; if (write_en !== 1'b1) begin n_err++; $display("FAIL ld_we got %0h want 1", write_en); end
    n_vec++; if (rd !== 5'd9) begin n_err++; $display("FAIL ld_rd got %0h want 9", rd); end
    n_vec++; if (data_w !== 64'h1234) begin n_err++; $display("FAIL ld_data got %0h want 1234", data_w); end
    cyc;
  endtask
  task automatic test_starvation;
    alu_valid = 1; alu_rd = 1; alu_data = 64'hA;
    for (int n = 0; n < 2; n++) begin
      ld_valid = 1; ld_rd = 12; ld_data = 64'hC0FFEE + 64'(n);
      mid; cyc; ld_valid = 0;
      for (int k = 1; k <= 4; k++) begin
        mid;
        n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL starve_win%0d got %0h want 1", k, alu_ready); end
        cyc;
      end
      mid;
      n_vec++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL starve_force got %0h want 0", alu_ready); end
      cyc; mid;
      n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL starve_release got %0h want 1", alu_ready); end
      n_vec++; if (write_en !== 1'b1 || rd !== 5'd12) begin n_err++; $display("FAIL starve_ld_rd got %0h/%0h want 1/c", write_en, rd); end
      n_vec++; if (data_w !== 64'hC0FFEE + 64'(n)) begin n_err++; $display("FAIL starve_ld_data got %0h want %0h", data_w, 64'hC0FFEE + 64'(n)); end
      cyc; mid;
      n_vec++; if (write_en !== 1'b1 || rd !== 5'd1) begin n_err++; $display("FAIL starve_alu_next got %0h/%0h want 1/1", write_en, rd); end
      cyc;
    end
    alu_valid = 0; cyc; cyc;
  endtask
  task automatic test_x0_drop;
    alu_valid = 1; alu_rd = 0; alu_data = 64'hFF;
    mid;
    n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL x0_alu_ready got %0h want 1", alu_ready); end
    cyc; alu_valid = 0; ld_valid = 1; ld_rd = 0; ld_data = 64'h55; mid;
    n_vec++; if (write_en !== 1'b0) begin n_err++; $display("FAIL x0_alu_we got %0h want 0", write_en); end
    n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL x0_ld_ready got %0h want 1", ld_ready); end
    cyc; ld_valid = 0; mid;
    n_vec++; if (busy !== 32'd0) begin n_err++; $display("FAIL x0_busy got %0h want 0", busy); end
    n_vec++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL x0_ld_queued got %0h want 0", alu_ready); end
    cyc; mid;
    n_vec++; if (write_en !== 1'b0) begin n_err++; $display("FAIL x0_ld_we got %0h want 0", write_en); end
    n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL x0_ld_popped got %0h want 1", alu_ready); end
    cyc;
  endtask
  task automatic test_fifo_wrap;
    q.delete(); rec = 1;
    alu_valid = 1; alu_rd = 0; alu_data = 0;
    for (int k = 1; k <= 4; k++) begin
      ld_valid = 1; ld_rd = 5'(k); ld_data = 64'(k) * 64'h111;
      mid;
      n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL wrap_fill%0d got %0h want 1", k, ld_ready); end
      cyc;
    end
    ld_rd = 5; ld_data = 64'h555; mid;
    n_vec++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL wrap_full got %0h want 0", ld_ready); end
    cyc; alu_valid = 0; ld_valid = 0; mid; cyc;
    for (int k = 5; k <= 6; k++) begin
      ld_valid = 1; ld_rd = 5'(k); ld_data = 64'(k) * 64'h111;
      mid;
      n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL wrap_refill%0d got %0h want 1", k, ld_ready); end
      cyc;
    end
    ld_valid = 0;
    repeat (6) cyc;
    rec = 0;
    n_vec++; if (q.size() !== 6) begin n_err++; $display("FAIL wrap_count got %0d want 6", q.size()); end
    for (int i = 0; i < q.size() && i < 6; i++) begin
      n_vec++;
      if (q[i].rd !== 5'(i + 1) || q[i].data !== 64'(i + 1) * 64'h111) begin
        n_err++; $display("FAIL wrap_order%0d got %0h/%0h want %0h/%0h", i, q[i].rd, q[i].data, i + 1, 64'(i + 1) * 64'h111);
      end
    end
  endtask
  task automatic test_reset_flush;
    alu_valid = 1; alu_rd = 0;
    for (int k = 5; k <= 7; k++) begin
      ld_valid = 1; ld_rd = 5'(k); ld_data = 64'(k);
      mid; cyc;
    end
    ld_valid = 0; rst = 1; mid;
    n_vec++; if (busy !== 32'hE0) begin n_err++; $display("FAIL flush_busy_pre got %0h want e0", busy); end
    n_vec++; if (alu_ready !== 1'b0 || ld_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got %0h/%0h want 0/0", alu_ready, ld_ready); end
    cyc; rst = 0; alu_valid = 0; mid;
    n_vec++; if (busy !== 32'd0) begin n_err++; $display("FAIL flush_busy got %0h want 0", busy); end
    for (int k = 0; k < 5; k++) begin
      mid;
      n_vec++; if (write_en !== 1'b0) begin n_err++; $display("FAIL flush_we%0d got %0h want 0", k, write_en); end
      cyc;
    end
  endtask
  initial begin
    test_reset;
    test_alu_only;
    test_load_idle;
    test_starvation;
    test_x0_drop;
    test_fifo_wrap;
    test_reset_flush;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Writeback stage directly upstream of reg_file; drives its single write port (rd_in, data_write, write_en).
- Merges two result sources into one write per cycle:
  - the ALU path, one result per cycle with a valid/ready handshake;
  - the load path, variable latency, buffered in a small FIFO.
- Arbitrates between the two, guarantees loads cannot starve, and drops writes to x0.
- Publishes a forwarding port and a busy mask for the issue/hazard logic.

Parameters:
- REG_DATA_WIDTH_POW, 6, log2 of data width (XLEN = 64).
- REG_MEM_DEPTH_POW, 5, log2 of register count (32).
- LD_FIFO_DEPTH_POW, 2, log2 of load FIFO depth (4 entries).
- STARVE_LIMIT, 4, consecutive cycles a non-empty load FIFO may lose arbitration before it is forced to win.

Ports:
- clk_in  in  1  clock; all state updates on posedge.
- rst_in  in  1  synchronous active-high reset.
- alu_valid_in  in  1  ALU result valid.
- alu_ready_out  out  1  ALU result accepted this cycle when high together with alu_valid_in.
- alu_rd_in  in  REG_MEM_DEPTH_POW  ALU destination register.
- alu_data_in  in  REG_DATA_WIDTH  ALU result.
- ld_valid_in  in  1  load result valid.
- ld_ready_out  out  1  load FIFO not full.
- ld_rd_in  in  REG_MEM_DEPTH_POW  load destination register.
- ld_data_in  in  REG_DATA_WIDTH  load data.
- rd_out  out  REG_MEM_DEPTH_POW  to reg_file rd_in.
- data_write_out  out  REG_DATA_WIDTH  to reg_file data_write.
- write_en_out  out  1  to reg_file write_en.
- busy_mask_out  out  REG_MEM_DEPTH  bit r = some queued load targets xr.
- fwd_valid_out  out  1  equals write_en_out; the registered write is visible for bypass.

Behaviour:
- Reset (rst_in = 1 at posedge):
  - write_en_out = 0, rd_out = 0, data_write_out = 0;
  - FIFO emptied (count = 0), starvation counter = 0;
  - busy_mask_out = 0 from the next cycle.
  - Reset mid-operation discards all queued loads and any pending write.
  - While rst_in is high, alu_ready_out = 0 and ld_ready_out = 0.
- Load FIFO:
  - Push on ld_valid_in && ld_ready_out.
  - ld_ready_out = (count < depth); it does not depend on a same-cycle pop.
  - Pop when the FIFO head is granted.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo depth; count width is LD_FIFO_DEPTH_POW+1.
- Arbitration, evaluated combinationally each cycle:
  - ld_grant = fifo_nonempty && (!alu_valid_in || starve_cnt == STARVE_LIMIT).
  - alu_ready_out = !ld_grant.
- Starvation counter:
  - Increments when fifo_nonempty && alu_valid_in && !ld_grant.
  - Clears to 0 on ld_grant or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Output register, one-cycle latency from grant/accept to write_en_out:
  - Source = FIFO head if ld_grant, else ALU input if alu_valid_in, else none.
  - write_en_out <= source present && source rd != 0.
  - rd_out and data_write_out are loaded only when a source is present; otherwise they hold their values.
- x0 writes:
  - The handshake completes (entry consumed or popped) but write_en_out stays 0.
  - Loads with rd = 0 are still queued; this keeps ordering simple.
- busy_mask_out is combinational over valid FIFO entries:
  - bit[rd] set for each entry with rd != 0;
  - bit 0 is always 0;
  - the output register is not included, because it is forwarded.
- The block applies no ordering between the ALU and load paths. The issue stage must stall on busy_mask_out to avoid WAW between paths.

Decomposition:
- Package reg_pkg holds:
  - REG_DATA_WIDTH_POW, REG_MEM_DEPTH_POW and the derived widths;
  - typedef wb_entry_t {rd, data}, shared with reg_file tests.
- One sub-module: wb_ld_fifo, a parameterised synchronous FIFO of wb_entry_t.
  - Ports: push, pop, full, empty, head, and per-entry valid/rd vectors for the busy mask.
- Arbitration, starvation counter and output register live in reg_writeback.

Test Plan:
- Reset flush: push 3 loads (rd = 5, 6, 7), assert rst_in for 1 cycle.
  -> write_en_out = 0 and busy_mask_out = 0 after reset; none of the 3 loads is ever written.
- ALU only: alu_valid_in = 1, rd = 3, data = 0xDEAD_BEEF.
  -> the next cycle has write_en_out = 1, rd_out = 3, data_write_out = 0xDEAD_BEEF, and fwd_valid_out = 1.
  -> reg_file x3 reads 0xDEAD_BEEF on the following cycle.
- Load with idle ALU: push load rd = 9, data = 0x1234.
  -> busy_mask_out[9] = 1 for exactly one cycle.
  -> write_en_out = 1 with rd_out = 9 one cycle after the grant.
- Starvation: alu_valid_in held high continuously, one load queued (rd = 12).
  -> the ALU wins 4 cycles, then alu_ready_out = 0 for exactly 1 cycle.
  -> the load is written (rd_out = 12), and starve_cnt returns to 0.
- FIFO full/wrap: alu_valid_in high with STARVE_LIMIT large, push 4 loads.
  -> ld_ready_out = 0 on the 5th.
  -> drain 2 and push 2 more; the 6 writes emerge in push order, with no loss across pointer wrap.
- x0 drop: ALU rd = 0, data = 0xFF, then a load with rd = 0.
  -> both handshakes complete, write_en_out stays 0, and busy_mask_out[0] = 0 throughout.
